// File: rtl/param_regfile_sb.sv
// param_regfile_sb: parametrised register file with NUM_RD combinational read
// ports, two prioritised write ports (port 1 wins on an address clash), an
// optional hardwired-zero register 0 and a per-register busy scoreboard.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> same-cycle write-to-read forwarding (port 1 over port 0);
//                the forwarded read port reports not-busy
//   undefined -> reads return stored contents; new data shows after the edge
module param_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [ADDR_W:0]            busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    // Read-port count outside 1..4 is rejected while elaborating.
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_cfg_err
        $error("param_regfile_sb: NUM_RD=%0d is outside the supported range 1..4", NUM_RD);
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;

    // Qualified enables: with a hardwired zero register, traffic to address 0
    // is discarded before it reaches storage or the scoreboard.
    logic wr0_ok;
    logic wr1_ok;
    logic iss_ok;

    assign wr0_ok = we0       && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr1_ok = we1       && !((ZERO_REG != 0) && (wa1 == '0));
    assign iss_ok = iss_valid && !((ZERO_REG != 0) && (iss_addr == '0));

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Next scoreboard state: writes retire producers, then an issue marks the
    // new producer so that set beats clear on the same register.
    always_comb begin
        busy_next = busy;
        if (wr0_ok) begin
            busy_next[wa0] = 1'b0;
        end
        if (wr1_ok) begin
            busy_next[wa1] = 1'b0;
        end
        if (iss_ok) begin
            busy_next[iss_addr] = 1'b1;
        end
    end

    // Scoreboard and its registered population count.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= popcount(busy_next);
        end
    end

    // Register storage; port 1 is applied last so it wins an address clash.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                mem[wa0] <= wd0;
            end
            if (wr1_ok) begin
                mem[wa1] <= wd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        // Combinational read with zero-register masking and optional forwarding.
        always_comb begin
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
            end else begin
                data = mem[addr];
            end
            bsy = busy[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr0_ok && (wa0 == addr)) begin
                data = wd0;
                bsy  = 1'b0;
            end
            if (wr1_ok && (wa1 == addr)) begin
                data = wd1;
                bsy  = 1'b0;
            end
`endif
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]                  = bsy;
    end

endmodule

// File: tb/tb_param_regfile_sb.sv
// Directed testbench for param_regfile_sb (4 read ports, 32x32, zero register).
module tb_param_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we0;
    logic [ADDR_W-1:0]        wa0;
    logic [DATA_W-1:0]        wd0;
    logic                     we1;
    logic [ADDR_W-1:0]        wa1;
    logic [DATA_W-1:0]        wd1;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic [ADDR_W:0]          busy_count;

    int vectors;
    int miscompares;

    param_regfile_sb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    // One clock edge; single-cycle controls drop afterwards, then settle.
    task automatic cycle();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        we0       = 1'b0;
        we1       = 1'b0;
        iss_valid = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] d;
        do_reset();
        for (int a = 0; a < 32; a += 4) begin
            rd_addr = {5'(a + 3), 5'(a + 2), 5'(a + 1), 5'(a)};
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                d = rd_data[k*DATA_W +: DATA_W];
                vectors++;
                if (d !== 32'h0) begin
                    miscompares++;
                    $display("FAIL reset_data addr %0d: got %h expected %h", a + k, d, 32'h0);
                end
            end
            vectors++;
            if (rd_busy !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_busy base %0d: got %b expected %b", a, rd_busy, 4'b0000);
            end
        end
        vectors++;
        if (busy_count !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d expected 0", busy_count);
        end
        // reg5 written then cleared by reset
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        cycle();
        rd_addr[4:0] = 5'd5;
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL write_reg5: got %h expected %h", rd_data[31:0], 32'hDEADBEEF);
        end
        do_reset();
        vectors++;
        if (rd_data[31:0] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_reg5: got %h expected %h", rd_data[31:0], 32'h0);
        end
        // write and issue in the reset cycle are ignored
        reset = 1'b1;
        we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66666666;
        iss_valid = 1'b1; iss_addr = 5'd6;
        cycle();
        rd_addr[4:0] = 5'd6;
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || busy_count !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_ignores_ops: got data %h busy %b count %0d expected 0/0/0",
                     rd_data[31:0], rd_busy[0], busy_count);
        end
    endtask

    task automatic test_dual_write();
        do_reset();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h22;
        cycle();
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h44;
        we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h88;
        cycle();
        rd_addr = {5'd0, 5'd8, 5'd4, 5'd3};
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h22) begin
            miscompares++;
            $display("FAIL same_addr_port1_wins: got %h expected %h", rd_data[31:0], 32'h22);
        end
        vectors++;
        if (rd_data[63:32] !== 32'h44) begin
            miscompares++;
            $display("FAIL dual_write_p0: got %h expected %h", rd_data[63:32], 32'h44);
        end
        vectors++;
        if (rd_data[95:64] !== 32'h88) begin
            miscompares++;
            $display("FAIL dual_write_p1: got %h expected %h", rd_data[95:64], 32'h88);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_addr = 5'd0;
        rd_addr = '0;
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_reg_same_cycle: got %h expected %h", rd_data[31:0], 32'h0);
        end
        cycle();
        vectors++;
        if (rd_data[31:0] !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_reg_data: got %h expected %h", rd_data[31:0], 32'h0);
        end
        vectors++;
        if (rd_busy !== 4'b0000) begin
            miscompares++;
            $display("FAIL zero_reg_busy: got %b expected %b", rd_busy, 4'b0000);
        end
        vectors++;
        if (busy_count !== 6'd0) begin
            miscompares++;
            $display("FAIL zero_reg_count: got %0d expected 0", busy_count);
        end
    endtask

    task automatic test_scoreboard();
        do_reset();
        rd_addr = {5'd0, 5'd0, 5'd0, 5'd7};
        iss_valid = 1'b1; iss_addr = 5'd7;
        cycle();
        vectors++;
        if (rd_busy[0] !== 1'b1 || busy_count !== 6'd1) begin
            miscompares++;
            $display("FAIL sb_issue: got busy %b count %0d expected 1/1", rd_busy[0], busy_count);
        end
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h77;
        iss_valid = 1'b1; iss_addr = 5'd7;
        cycle();
        vectors++;
        if (rd_busy[0] !== 1'b1 || busy_count !== 6'd1) begin
            miscompares++;
            $display("FAIL sb_set_beats_clear: got busy %b count %0d expected 1/1", rd_busy[0], busy_count);
        end
        // re-issue to a busy register does not double count
        iss_valid = 1'b1; iss_addr = 5'd7;
        cycle();
        vectors++;
        if (busy_count !== 6'd1) begin
            miscompares++;
            $display("FAIL sb_reissue_count: got %0d expected 1", busy_count);
        end
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h78;
        cycle();
        vectors++;
        if (rd_busy[0] !== 1'b0 || busy_count !== 6'd0) begin
            miscompares++;
            $display("FAIL sb_clear_port1: got busy %b count %0d expected 0/0", rd_busy[0], busy_count);
        end
        vectors++;
        if (rd_data[31:0] !== 32'h78) begin
            miscompares++;
            $display("FAIL sb_write_data: got %h expected %h", rd_data[31:0], 32'h78);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp_d;
        logic              exp_b;
        do_reset();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1234;
        cycle();
        iss_valid = 1'b1; iss_addr = 5'd9;
        cycle();
        rd_addr = {5'd0, 5'd0, 5'd10, 5'd9};
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hCAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'hCAFE; exp_b = 1'b0;
`else
        exp_d = 32'h1234; exp_b = 1'b1;
`endif
        vectors++;
        if (rd_data[31:0] !== exp_d) begin
            miscompares++;
            $display("FAIL bypass_same_cycle_data: got %h expected %h", rd_data[31:0], exp_d);
        end
        vectors++;
        if (rd_busy[0] !== exp_b) begin
            miscompares++;
            $display("FAIL bypass_same_cycle_busy: got %b expected %b", rd_busy[0], exp_b);
        end
        cycle();
        vectors++;
        if (rd_data[31:0] !== 32'hCAFE || rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_next_cycle: got %h/%b expected %h/0", rd_data[31:0], rd_busy[0], 32'hCAFE);
        end
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hA0A0;
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'hB0B0;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'hB0B0;
`else
        exp_d = 32'h0;
`endif
        vectors++;
        if (rd_data[63:32] !== exp_d) begin
            miscompares++;
            $display("FAIL bypass_port1_priority: got %h expected %h", rd_data[63:32], exp_d);
        end
        cycle();
        vectors++;
        if (rd_data[63:32] !== 32'hB0B0) begin
            miscompares++;
            $display("FAIL bypass_port1_stored: got %h expected %h", rd_data[63:32], 32'hB0B0);
        end
    endtask

    task automatic test_multi_read();
        do_reset();
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h1001;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h2002;
        cycle();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h3003;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h4004;
        cycle();
        for (int a = 1; a <= 3; a++) begin
            iss_valid = 1'b1; iss_addr = 5'(a);
            cycle();
        end
        rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        vectors++;
        if (rd_busy !== 4'b0111) begin
            miscompares++;
            $display("FAIL multi_busy: got %b expected %b", rd_busy, 4'b0111);
        end
        vectors++;
        if (busy_count !== 6'd3) begin
            miscompares++;
            $display("FAIL multi_count: got %0d expected 3", busy_count);
        end
        vectors++;
        if (rd_data !== {32'h4004, 32'h3003, 32'h2002, 32'h1001}) begin
            miscompares++;
            $display("FAIL multi_data: got %h expected %h", rd_data,
                     {32'h4004, 32'h3003, 32'h2002, 32'h1001});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        rd_addr     = '0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_valid = 1'b0; iss_addr = '0;
        test_reset();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_bypass();
        test_multi_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
